// File: rtl/timer_bank_if.sv
// Bus port bundle for timer_bank: CPU-to-device bridge address/data/write-enable
// towards the device and combinational read data back.
interface timer_bank_if;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;

  modport master (output Addr, output WD, output WE, input RD);
  modport slave  (input Addr, input WD, input WE, output RD);
endinterface

// File: rtl/timer_bank.sv
// timer_bank: N_CH independent down-counting timers on the bridge bus.
// Per channel: CTRL (EN/MODE/IM/PEND/PSC), PRESET, COUNT (RO), CMP.
// Modes: 0/3 one-shot IRQ, 1 auto-reload IRQ, 2 auto-reload PWM.
// Optional feature macro: PRESCALER_EN (CTRL[15:8] prescaler, tick every PSC+1 cycles).
module timer_bank #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int unsigned CH_STRIDE = 16
) (
  input  logic            CLK,
  input  logic            RST,
  timer_bank_if.slave     bus,
  output logic [N_CH-1:0] IRQ,
  output logic [N_CH-1:0] PWM_OUT
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  localparam int unsigned SH = $clog2(CH_STRIDE);

  logic [31:0]     w_off;
  logic [31:0]     w_ch;
  logic [31:0]     w_inner;
  logic            w_hit;
  logic [N_CH-1:0] w_sel;
  logic [31:0]     w_rd_ch [N_CH];

  assign w_off   = bus.Addr - BASE_ADDR;
  assign w_ch    = w_off >> SH;
  assign w_inner = w_off & (CH_STRIDE - 1);
  // Below-base addresses wrap to a huge channel number and miss naturally.
  assign w_hit   = (w_ch < N_CH) && (w_inner < 32'd16);

  // Channel select decode
  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) w_sel[c] = w_hit && (w_ch == c);
  end

  // Read mux: only the selected channel contributes
  always_comb begin
    bus.RD = '0;
    for (int unsigned c = 0; c < N_CH; c++)
      if (w_sel[c]) bus.RD = bus.RD | w_rd_ch[c];
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t           r_state, w_state_d;
    logic             r_en, w_en_d;
    logic [1:0]       r_mode;
    logic             r_im;
    logic             r_pend, w_pend_d;
    logic [CNT_W-1:0] r_preset, r_count, w_count_d, r_cmp;
    logic             w_tick;
    logic [7:0]       w_psc_rd;
    logic             w_we_ctrl, w_we_preset, w_we_cmp;
    logic [31:0]      w_rd;

    assign w_we_ctrl   = bus.WE && w_sel[c] && (w_off[3:0] == 4'h0);
    assign w_we_preset = bus.WE && w_sel[c] && (w_off[3:0] == 4'h4);
    assign w_we_cmp    = bus.WE && w_sel[c] && (w_off[3:0] == 4'hC);

`ifdef PRESCALER_EN
    logic [7:0] r_psc, r_psc_cnt, w_psc_cnt_d;
    assign w_tick   = (r_psc_cnt >= r_psc);
    assign w_psc_rd = r_psc;

    // Prescaler divide value and running prescale count
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        r_psc     <= '0;
        r_psc_cnt <= '0;
      end else begin
        if (w_we_ctrl) r_psc <= bus.WD[15:8];
        r_psc_cnt <= w_psc_cnt_d;
      end
    end
`else
    assign w_tick   = 1'b1;
    assign w_psc_rd = '0;
`endif

    // Next-state, counter, EN and PEND update for this channel.
    // Expiry is resolved on the CNT cycle that sees COUNT==0, so the register
    // never holds S_INT; this gives the PRESET+2 period with COUNT==0 visible in CNT.
    always_comb begin
      w_state_d = r_state;
      w_count_d = r_count;
      w_en_d    = r_en;
      w_pend_d  = r_pend;
`ifdef PRESCALER_EN
      w_psc_cnt_d = r_psc_cnt;
`endif
      if (w_we_ctrl) begin
        w_en_d = bus.WD[0];
        if (bus.WD[4]) w_pend_d = 1'b0;
      end
      case (r_state)
        S_IDLE: if (w_en_d) w_state_d = S_LOAD;
        S_LOAD: begin
          w_count_d = r_preset;
          w_state_d = S_CNT;
`ifdef PRESCALER_EN
          w_psc_cnt_d = '0;
`endif
        end
        S_CNT: begin
          if (r_count == '0) begin
            case (r_mode)
              2'd1: begin
                w_pend_d  = 1'b1;
                w_state_d = S_LOAD;
              end
              2'd2: w_state_d = S_LOAD;
              default: begin
                w_pend_d  = 1'b1;
                w_en_d    = 1'b0;
                w_state_d = S_IDLE;
              end
            endcase
          end else begin
            if (w_tick) w_count_d = r_count - CNT_W'(1);
`ifdef PRESCALER_EN
            w_psc_cnt_d = w_tick ? '0 : r_psc_cnt + 8'd1;
`endif
          end
        end
        default: w_state_d = S_IDLE;
      endcase
      // Disabling from the bus stops the channel with COUNT frozen.
      if (w_we_ctrl && !bus.WD[0]) begin
        w_state_d = S_IDLE;
        w_count_d = r_count;
      end
    end

    // Channel state and registers
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        r_state  <= S_IDLE;
        r_en     <= 1'b0;
        r_mode   <= '0;
        r_im     <= 1'b0;
        r_pend   <= 1'b0;
        r_preset <= '0;
        r_count  <= '0;
        r_cmp    <= '0;
      end else begin
        r_state <= w_state_d;
        r_en    <= w_en_d;
        r_pend  <= w_pend_d;
        r_count <= w_count_d;
        if (w_we_ctrl) begin
          r_mode <= bus.WD[2:1];
          r_im   <= bus.WD[3];
        end
        if (w_we_preset) r_preset <= bus.WD[CNT_W-1:0];
        if (w_we_cmp)    r_cmp    <= bus.WD[CNT_W-1:0];
      end
    end

    // Per-channel register read word, zero-extended
    always_comb begin
      w_rd = '0;
      case (w_off[3:0])
        4'h0: begin
          w_rd[0]    = r_en;
          w_rd[2:1]  = r_mode;
          w_rd[3]    = r_im;
          w_rd[4]    = r_pend;
          w_rd[15:8] = w_psc_rd;
        end
        4'h4:    w_rd[CNT_W-1:0] = r_preset;
        4'h8:    w_rd[CNT_W-1:0] = r_count;
        4'hC:    w_rd[CNT_W-1:0] = r_cmp;
        default: w_rd = '0;
      endcase
    end

    assign w_rd_ch[c]  = w_rd;
    assign IRQ[c]      = r_pend && r_im;
    assign PWM_OUT[c]  = (r_mode == 2'd2) && (r_state == S_CNT) && (r_count <= r_cmp);
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank with an expected-value scoreboard queue.
module tb_timer_bank;
  logic       CLK;
  logic       RST;
  logic [3:0] irq;
  logic [3:0] pwm;

  timer_bank_if bus_if ();

  timer_bank #(
    .N_CH(4), .CNT_W(32), .BASE_ADDR(32'h0000_7F00), .CH_STRIDE(16)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus_if), .IRQ(irq), .PWM_OUT(pwm)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drive one bus write; it is captured on the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    bus_if.Addr = a;
    bus_if.WD   = d;
    bus_if.WE   = 1'b1;
    @(posedge CLK);
    #1;
    bus_if.WE   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_if.Addr = a;
    #1;
    d = bus_if.RD;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int          m;

    RST = 1'b0;
    bus_if.Addr = '0;
    bus_if.WD   = '0;
    bus_if.WE   = 1'b0;

    // Reset state
    sb_push("rst_irq", 32'h0);
    sb_push("rst_pwm", 32'h0);
    sb_push("rst_ctrl0", 32'h0);
    wait_edges(2);
    sb_check(32'(irq));
    sb_check(32'(pwm));
    rd(32'h7F00, d); sb_check(d);
    @(negedge CLK);
    RST = 1'b1;

    // 1) one-shot, mode 0, IM=1, PRESET=5
    wr(32'h7F04, 32'd5);
    wr(32'h7F00, 32'h9);                     // E0
    sb_push("t1_cnt_e3", 32'd3);
    sb_push("t1_irq_e6", 32'h0);
    sb_push("t1_irq_e7", 32'h1);
    sb_push("t1_cnt_e7", 32'h0);
    sb_push("t1_ctrl_e7", 32'h18);
    wait_edges(3); rd(32'h7F08, d); sb_check(d);
    wait_edges(3); sb_check(32'(irq[0]));
    wait_edges(1); sb_check(32'(irq[0]));
    rd(32'h7F08, d); sb_check(d);
    rd(32'h7F00, d); sb_check(d);
    wr(32'h7F00, 32'h10);
    sb_push("t1_irq_clr", 32'h0);
    sb_push("t1_ctrl_clr", 32'h0);
    sb_check(32'(irq[0]));
    rd(32'h7F00, d); sb_check(d);

    // 2) auto-reload, mode 1, PRESET=7
    wr(32'h7F14, 32'd7);
    wr(32'h7F10, 32'hB);                     // E0
    sb_push("t2_ctrl_e8", 32'h0B);
    sb_push("t2_ctrl_e9", 32'h1B);
    sb_push("t2_irq_e9", 32'h1);
    sb_push("t2_cnt_e9", 32'h0);
    sb_push("t2_cnt_e10", 32'd7);
    wait_edges(8); rd(32'h7F10, d); sb_check(d);
    wait_edges(1); rd(32'h7F10, d); sb_check(d);
    sb_check(32'(irq[1]));
    rd(32'h7F18, d); sb_check(d);
    wait_edges(1); rd(32'h7F18, d); sb_check(d);
    wr(32'h7F10, 32'h1B);                    // E11: W1C between periods
    sb_push("t2_ctrl_w1c", 32'h0B);
    sb_push("t2_irq_w1c", 32'h0);
    rd(32'h7F10, d); sb_check(d);
    sb_check(32'(irq[1]));
    wr(32'h7F14, 32'd3);                     // E12: PRESET change mid-run
    sb_push("t2_cnt_e12", 32'd5);
    sb_push("t2_ctrl_e17", 32'h0B);
    sb_push("t2_cnt_e17", 32'h0);
    sb_push("t2_set_wins", 32'h1B);
    sb_push("t2_cnt_newpreset", 32'd3);
    rd(32'h7F18, d); sb_check(d);
    wait_edges(5); rd(32'h7F10, d); sb_check(d);
    rd(32'h7F18, d); sb_check(d);
    wr(32'h7F10, 32'h1B);                    // E18: clear collides with set
    rd(32'h7F10, d); sb_check(d);
    wait_edges(1); rd(32'h7F18, d); sb_check(d);   // E19
    wr(32'h7F10, 32'h10);                    // E20: disable mid-count
    sb_push("t2_ctrl_off", 32'h0);
    sb_push("t2_cnt_frozen", 32'd3);
    rd(32'h7F10, d); sb_check(d);
    wait_edges(3); rd(32'h7F18, d); sb_check(d);
    wr(32'h7F14, 32'd6);
    wr(32'h7F10, 32'h3);                     // re-enable restarts from LOAD
    sb_push("t2_cnt_restart", 32'd6);
    wait_edges(1); rd(32'h7F18, d); sb_check(d);
    wr(32'h7F10, 32'h10);

    // 3) PWM, mode 2, PRESET=9, CMP=3
    wr(32'h7F24, 32'd9);
    wr(32'h7F2C, 32'd3);
    wr(32'h7F20, 32'h5);                     // E0
    for (int k = 1; k <= 22; k++) begin
      m = (k - 1) % 11;
      sb_push($sformatf("t3_pwm_e%0d", k), 32'((m <= 9) && ((9 - m) <= 3)));
    end
    for (int k = 1; k <= 22; k++) begin
      wait_edges(1);
      sb_check(32'(pwm[2]));
    end
    sb_push("t3_irq", 32'h0);
    sb_push("t3_ctrl", 32'h05);
    sb_check(32'(irq[2]));
    rd(32'h7F20, d); sb_check(d);
    wr(32'h7F20, 32'h0);
    sb_push("t3_pwm_off", 32'h0);
    wait_edges(2); sb_check(32'(pwm[2]));

    // 5) PRESET=0, IM=0, then set IM
    wr(32'h7F34, 32'd0);
    wr(32'h7F30, 32'h1);                     // E0
    sb_push("t5_ctrl_e1", 32'h01);
    sb_push("t5_ctrl_e2", 32'h10);
    sb_push("t5_irq_e2", 32'h0);
    wait_edges(1); rd(32'h7F30, d); sb_check(d);
    wait_edges(1); rd(32'h7F30, d); sb_check(d);
    sb_check(32'(irq[3]));
    wr(32'h7F30, 32'h8);
    sb_push("t5_irq_im", 32'h1);
    sb_push("t5_ctrl_im", 32'h18);
    sb_check(32'(irq[3]));
    rd(32'h7F30, d); sb_check(d);

    // 4) asynchronous reset mid-count (also CMP>=PRESET gives constant PWM)
    wr(32'h7F04, 32'd100);
    wr(32'h7F24, 32'd5);
    wr(32'h7F2C, 32'd5);
    wr(32'h7F00, 32'h9);                     // ch0 starts one edge before E0
    wr(32'h7F20, 32'h5);                     // E0
    for (int k = 1; k <= 8; k++) begin
      m = (k - 1) % 7;
      sb_push($sformatf("t4_pwm_e%0d", k), 32'((m <= 5) && ((5 - m) <= 5)));
    end
    sb_push("t4_cnt_e8", 32'd92);
    for (int k = 1; k <= 8; k++) begin
      wait_edges(1);
      sb_check(32'(pwm[2]));
    end
    rd(32'h7F08, d); sb_check(d);
    sb_push("t4_rst_irq", 32'h0);
    sb_push("t4_rst_pwm", 32'h0);
    sb_push("t4_rst_cnt0", 32'h0);
    sb_push("t4_rst_ctrl0", 32'h0);
    sb_push("t4_rst_preset2", 32'h0);
    RST = 1'b0;                               // mid-cycle, no clock edge
    #1;
    sb_check(32'(irq));
    sb_check(32'(pwm));
    rd(32'h7F08, d); sb_check(d);
    rd(32'h7F00, d); sb_check(d);
    rd(32'h7F24, d); sb_check(d);
    wait_edges(2);
    @(negedge CLK);
    RST = 1'b1;
    sb_push("t4_post_cnt", 32'h0);
    sb_push("t4_post_ctrl", 32'h0);
    sb_push("t4_post_irq", 32'h0);
    sb_push("t4_noen_cnt", 32'h0);
    wait_edges(5);
    rd(32'h7F08, d); sb_check(d);
    rd(32'h7F00, d); sb_check(d);
    sb_check(32'(irq));
    wr(32'h7F04, 32'd3);
    wait_edges(4); rd(32'h7F08, d); sb_check(d);

    // 6) prescaler (or its absence in the default build)
    wr(32'h7F04, 32'd4);
    wr(32'h7F00, 32'h0209);                  // E0
`ifdef PRESCALER_EN
    sb_push("t6_ctrl_e13", 32'h0209);
    sb_push("t6_ctrl_e14", 32'h0218);
    sb_push("t6_irq_e14", 32'h1);
    wait_edges(13); rd(32'h7F00, d); sb_check(d);
    wait_edges(1);  rd(32'h7F00, d); sb_check(d);
    sb_check(32'(irq[0]));
`else
    sb_push("t6_ctrl_e5", 32'h0009);
    sb_push("t6_ctrl_e6", 32'h0018);
    sb_push("t6_irq_e6", 32'h1);
    wait_edges(5); rd(32'h7F00, d); sb_check(d);
    wait_edges(1); rd(32'h7F00, d); sb_check(d);
    sb_check(32'(irq[0]));
`endif

    // Address decode and write filtering
    wr(32'h7F44, 32'h0000_ABCD);            // channel 4 does not exist
    wr(32'h7F08, 32'h55);                    // COUNT is read-only
    wr(32'h7F1C, 32'hFFFF_FFFF);
    wr(32'h7F10, 32'hFFFF_FFE6);
    sb_push("a_preset0", 32'd4);
    sb_push("a_ch4", 32'h0);
    sb_push("a_7f50", 32'h0);
    sb_push("a_count_ro", 32'h0);
    sb_push("a_nonword", 32'h0);
    sb_push("a_below", 32'h0);
    sb_push("a_cmp1", 32'hFFFF_FFFF);
`ifdef PRESCALER_EN
    sb_push("a_ctrl1", 32'h0000_FF06);
`else
    sb_push("a_ctrl1", 32'h0000_0006);
`endif
    rd(32'h7F04, d); sb_check(d);
    rd(32'h7F44, d); sb_check(d);
    rd(32'h7F50, d); sb_check(d);
    rd(32'h7F08, d); sb_check(d);
    rd(32'h7F1E, d); sb_check(d);
    rd(32'h7EFC, d); sb_check(d);
    rd(32'h7F1C, d); sb_check(d);
    rd(32'h7F10, d); sb_check(d);

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: %0d unchecked expected values, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
